// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the push-button conditioner: the per-channel
// debounce FSM state type and the idle (released) level of the raw
// active-low key inputs.
// -----------------------------------------------------------------------------
package key_pkg;

    // REL / PRS are the stable states; WAIT_P / WAIT_R are the hold
    // periods during which a candidate change must stay put.
    typedef enum logic [1:0] {
        REL    = 2'b00,
        WAIT_P = 2'b01,
        PRS    = 2'b10,
        WAIT_R = 2'b11
    } key_state_t;

    // Level of an unpressed active-low key; the synchroniser resets to it.
    localparam logic KEY_IDLE = 1'b1;

endpackage : key_pkg

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
// One key channel: 2-FF synchroniser, debounce FSM with hold counter, and
// registered level / press / release outputs.
//
// Ports:
//   i_clk         system clock
//   i_rst         asynchronous active-high reset
//   i_key_n       raw active-low key, asynchronous to i_clk
//   o_key_level   debounced key state, 1 = pressed
//   o_key_press   1-cycle pulse when a press is accepted
//   o_key_release 1-cycle pulse when a release is accepted
// -----------------------------------------------------------------------------
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 250000,
    parameter int CNT_W        = $clog2(DEBOUNCE_CYC)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_key_level,
    output logic o_key_press,
    output logic o_key_release
);

    // Last count value of a hold period; the FSM leaves WAIT here, so the
    // counter never needs to wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_meta;
    logic             key_s;
    key_state_t       state;
    logic [CNT_W-1:0] cnt;

    // Two-stage synchroniser; resets to the released level so a reset
    // never looks like a key edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_meta <= KEY_IDLE;
            key_s     <= KEY_IDLE;
        end else begin
            // NOTE: non-blocking so both stages sample the pre-edge values;
            // blocking here would collapse the chain into a single flop.
            sync_meta <= i_key_n;
            key_s     <= sync_meta;
        end
    end

    // Debounce FSM. Outputs are set on the transition itself so they are
    // registered alongside the state they describe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= REL;
            cnt           <= '0;
            o_key_level   <= 1'b0;
            o_key_press   <= 1'b0;
            o_key_release <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle and are raised only on the
            // accepting transition, which makes them exactly one cycle wide.
            o_key_press   <= 1'b0;
            o_key_release <= 1'b0;

            unique case (state)
                REL: begin
                    if (!key_s) begin
                        state <= WAIT_P;
                        cnt   <= '0;
                    end
                end

                WAIT_P: begin
                    if (key_s) begin
                        // Bounce: back to stable released, nothing reported.
                        state <= REL;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= PRS;
                        o_key_level <= 1'b1;
                        o_key_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                PRS: begin
                    if (key_s) begin
                        state <= WAIT_R;
                        cnt   <= '0;
                    end
                end

                WAIT_R: begin
                    if (!key_s) begin
                        // Bounce: back to stable pressed, level stays high.
                        state <= PRS;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= REL;
                        o_key_level   <= 1'b0;
                        o_key_release <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state       <= REL;
                    cnt         <= '0;
                    o_key_level <= 1'b0;
                end
            endcase
        end
    end

endmodule : key_debounce_ch

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Multi-channel push-button conditioner. Each raw active-low key is
// synchronised and debounced independently, producing a clean active-high
// level plus single-cycle press/release pulses for the downstream logic.
//
// Ports:
//   i_clk         system clock (50 MHz board clock)
//   i_rst         asynchronous active-high reset
//   i_key_n       [N_KEYS] raw active-low keys
//   o_key_level   [N_KEYS] debounced state, 1 = pressed
//   o_key_press   [N_KEYS] 1-cycle pulse per accepted press
//   o_key_release [N_KEYS] 1-cycle pulse per accepted release
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int N_KEYS       = 2,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int CNT_W        = $clog2(DEBOUNCE_CYC)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_KEYS-1:0] i_key_n,
    output logic [N_KEYS-1:0] o_key_level,
    output logic [N_KEYS-1:0] o_key_press,
    output logic [N_KEYS-1:0] o_key_release
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .CNT_W        (CNT_W)
        ) u_ch (
            .i_clk         (i_clk),
            .i_rst         (i_rst),
            .i_key_n       (i_key_n[g]),
            .o_key_level   (o_key_level[g]),
            .o_key_press   (o_key_press[g]),
            .o_key_release (o_key_release[g])
        );
    end

endmodule : key_debounce

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
// Self-checking bench for key_debounce with DEBOUNCE_CYC=4, N_KEYS=2.
// Reference model: each channel accepts a change when the last
// DEBOUNCE_CYC+1 synchronised samples all disagree with the current level;
// the synchronised sample is the raw input two sampling edges earlier.
// -----------------------------------------------------------------------------
module tb_key_debounce;

    localparam int N = 2;
    localparam int D = 4;

    logic         i_clk;
    logic         i_rst;
    logic [N-1:0] i_key_n;
    logic [N-1:0] o_key_level;
    logic [N-1:0] o_key_press;
    logic [N-1:0] o_key_release;

    int n_checks = 0;
    int n_errors = 0;

    key_debounce #(
        .N_KEYS       (N),
        .DEBOUNCE_CYC (D),
        .CNT_W        (2)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_key_n       (i_key_n),
        .o_key_level   (o_key_level),
        .o_key_press   (o_key_press),
        .o_key_release (o_key_release)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [1:0]   m_pipe [N];   // raw samples still travelling through the sync
    logic [D:0]   m_hist [N];   // last D+1 samples seen by the debouncer
    logic [N-1:0] m_level;
    logic [N-1:0] m_press;
    logic [N-1:0] m_release;

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_pipe[c] = 2'b11;
            m_hist[c] = '1;
        end
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge i_clk or posedge i_rst);
            if (i_rst) begin
                model_reset();
            end else begin
                m_press   = '0;
                m_release = '0;
                for (int c = 0; c < N; c++) begin
                    logic seen;
                    seen      = m_pipe[c][1];
                    m_pipe[c] = {m_pipe[c][0], i_key_n[c]};
                    m_hist[c] = {m_hist[c][D-1:0], seen};
                    // In key_n polarity, a sample disagreeing with the
                    // debounced level has the same numeric value as it.
                    if (m_hist[c] == {(D+1){m_level[c]}}) begin
                        if (m_level[c]) m_release[c] = 1'b1;
                        else            m_press[c]   = 1'b1;
                        m_level[c] = ~m_level[c];
                    end
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge i_clk);
            check("model_level",   o_key_level,   m_level);
            check("model_press",   o_key_press,   m_press);
            check("model_release", o_key_release, m_release);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // From edge E (caller has just waited for it): outputs hold their old
    // level through E+5, change with the pulse at E+6, pulse gone at E+7.
    task automatic expect_accept(input string name, input logic [N-1:0] lvl_before,
                                 input logic [N-1:0] lvl_after, input logic [N-1:0] prs,
                                 input logic [N-1:0] rel);
        repeat (5) @(posedge i_clk);
        #1;
        check({name, "_lvl_e5"},   o_key_level, lvl_before);
        check({name, "_prs_e5"},   o_key_press, '0);
        check({name, "_rel_e5"},   o_key_release, '0);
        @(posedge i_clk);
        #1;
        check({name, "_lvl_e6"},   o_key_level, lvl_after);
        check({name, "_prs_e6"},   o_key_press, prs);
        check({name, "_rel_e6"},   o_key_release, rel);
        @(posedge i_clk);
        #1;
        check({name, "_lvl_e7"},   o_key_level, lvl_after);
        check({name, "_prs_e7"},   o_key_press, '0);
        check({name, "_rel_e7"},   o_key_release, '0);
    endtask

    task automatic drive_and_edge(input logic [N-1:0] v);
        @(negedge i_clk);
        i_key_n = v;
        @(posedge i_clk);
    endtask

    // Bounce pattern table, one entry per cycle, exercised against the model.
    logic [N-1:0] bounce_pat [24] = '{
        2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b11, 2'b00,
        2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10,
        2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11
    };

    initial begin
        i_rst   = 1'b1;
        i_key_n = 2'b11;

        // Reset state.
        repeat (3) @(negedge i_clk);
        check("rst_level",   o_key_level,   2'b00);
        check("rst_press",   o_key_press,   2'b00);
        check("rst_release", o_key_release, 2'b00);
        i_rst = 1'b0;
        repeat (20) begin
            @(negedge i_clk);
            check("idle_level", o_key_level, 2'b00);
            check("idle_press", o_key_press, 2'b00);
        end

        // Clean press and release on channel 0; channel 1 untouched.
        drive_and_edge(2'b10);
        expect_accept("press0", 2'b00, 2'b01, 2'b01, 2'b00);
        drive_and_edge(2'b11);
        expect_accept("release0", 2'b01, 2'b00, 2'b00, 2'b01);

        // Bounce: 3 low samples are rejected.
        @(negedge i_clk);
        i_key_n = 2'b10;
        repeat (3) @(negedge i_clk);
        i_key_n = 2'b11;
        repeat (10) begin
            @(negedge i_clk);
            check("bounce_level", o_key_level, 2'b00);
            check("bounce_press", o_key_press, 2'b00);
        end
        // Then a steady press is accepted 6 cycles after its first sample.
        drive_and_edge(2'b10);
        expect_accept("press_after_bounce", 2'b00, 2'b01, 2'b01, 2'b00);
        drive_and_edge(2'b11);
        expect_accept("release_after_bounce", 2'b01, 2'b00, 2'b00, 2'b01);

        // Simultaneous press and release on both channels.
        drive_and_edge(2'b00);
        expect_accept("press_both", 2'b00, 2'b11, 2'b11, 2'b00);
        drive_and_edge(2'b11);
        expect_accept("release_both", 2'b11, 2'b00, 2'b00, 2'b11);

        // Bounce table, checked cycle by cycle against the model.
        foreach (bounce_pat[i]) begin
            @(negedge i_clk);
            i_key_n = bounce_pat[i];
        end
        repeat (12) @(negedge i_clk);

        // Mid-operation reset: channel 1 held pressed, channel 0 mid-WAIT_P.
        drive_and_edge(2'b01);
        expect_accept("press1", 2'b00, 2'b10, 2'b10, 2'b00);
        drive_and_edge(2'b00);
        repeat (4) @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_level",   o_key_level,   2'b00);
        check("async_rst_press",   o_key_press,   2'b00);
        check("async_rst_release", o_key_release, 2'b00);
        @(negedge i_clk);
        i_rst = 1'b0;
        // Keys still held low: both become new presses after reset.
        @(posedge i_clk);
        expect_accept("press_after_rst", 2'b00, 2'b11, 2'b11, 2'b00);
        drive_and_edge(2'b11);
        expect_accept("release_after_rst", 2'b11, 2'b00, 2'b00, 2'b11);

        repeat (5) @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_key_debounce
